cg_memory_initiator: RTL and testbench
======================================

Name: cg_memory_initiator

Overview:
Initiator (requester) end of the CommonGoods memory interface. It accepts single read/write commands from a client (core LSU, DMA, fetch) over a valid/ready command channel and drives the memory-side write channel (wen/wvalid/waddr/wdata) and read channel (arvalid/araddr/rready). It returns one response per command, with a per-access timeout. It sits between any client and cg_memory_beh or a synthesizable memory with the same interface.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address bus width in bits
TIMEOUT_CYCLES, 64, maximum cycles waited for wready/arready/rvalid before an error response; must be at least 1

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  client command valid
cmd_ready  output  1  initiator can accept a command
cmd_we  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  command address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  client accepts response
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  output  1  access timed out
mem_wen  output  1  write enable
mem_wvalid  output  1  write request valid
mem_wready  input  1  memory accepts write
mem_waddr  output  ADDR_WIDTH  write address
mem_wdata  output  DATA_WIDTH  write data
mem_arvalid  output  1  read address valid
mem_arready  input  1  memory accepts read address
mem_araddr  output  ADDR_WIDTH  read address
mem_rvalid  input  1  read data valid
mem_rdata  input  DATA_WIDTH  read data
mem_rready  output  1  initiator accepts read data

Behaviour:
- Reset (async, rst_n=0): state IDLE. cmd_ready=1; all other outputs 0, including the address and data outputs. The timeout counter is cleared.
- States: IDLE, WR, RA, RD, RSP.
- IDLE: cmd_ready=1. On cmd_valid, capture we/addr/wdata in one cycle. Next state is WR if we=1, otherwise RA. cmd_ready=0 in every other state, so only one command is in flight.
- WR: drive mem_wen=mem_wvalid=1 with waddr and wdata held stable. On mem_wready=1, set rsp_err=0 and rsp_rdata=0, then go to RSP.
- RA: drive mem_arvalid=1 and araddr. On mem_arready=1, go to RD.
- RD: mem_rready=1. On mem_rvalid=1, register mem_rdata into rsp_rdata and go to RSP.
- Same-cycle shortcut: if mem_arready and mem_rvalid are both 1 in RA, data is accepted that cycle and the state goes directly to RSP. mem_rready is therefore also asserted in RA.
- Minimum latency: command accepted at edge N; write ack or read response has rsp_valid=1 at edge N+2 against a zero-wait memory.
- RSP: rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready. On the rsp_valid&rsp_ready cycle, return to IDLE. cmd_ready rises the next cycle; there is no combinational ready path.
- Timeout: the counter clears on entry to WR/RA/RD and increments each cycle spent waiting in those states.
  - When it reaches TIMEOUT_CYCLES-1 without a handshake, drop all mem_* valids.
  - Set rsp_err=1 and rsp_rdata=0, then go to RSP.
  - A handshake that arrives in the same cycle as expiry wins (no error).
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- mem_rvalid seen outside RA/RD is ignored. mem_wready outside WR is ignored.
- Reset mid-transaction aborts immediately: outputs return to reset values and no response is issued.
- Ordering: commands complete strictly in acceptance order. A read issued after a write to the same address returns the written data.

Decomposition:
- Shared package cg_mem_pkg: state enum typedef (IDLE, WR, RA, RD, RSP) and response struct typedef (rdata, err).
- Single module, no sub-module. The timeout counter is a few lines inline.

Test Plan:
- Write 0x514 <- 0x114, zero-wait memory -> mem_wvalid=1 for one cycle; rsp_valid at N+2 with rsp_err=0 and rsp_rdata=0.
- Writes 0x515 <- 0x214 and 0x516 <- 0xAAAAAAAA, then read 0x514 -> rsp_rdata=0x114, rsp_err=0.
- Write 0x516 <- 0x314, then read 0x516 back-to-back -> rsp_rdata=0x314 (ordering preserved).
- Memory holds mem_arready low 3 cycles and mem_rvalid low 2 more -> arvalid/araddr stable throughout; response is correct data.
- TIMEOUT_CYCLES=4 and mem_wready stuck 0 -> wvalid drops after 4 cycles; rsp_err=1, rsp_rdata=0.
- rsp_ready held 0 for 5 cycles, then rst_n pulsed low during RD on the next command -> response is held stable, then all outputs reach reset values asynchronously and cmd_ready=1 after reset.

Source files
------------

// File: rtl/cg_mem_pkg.sv
// Shared types for the CommonGoods memory initiator: FSM state encoding
// and the registered response record returned to the client.
package cg_mem_pkg;

  // Width of the response data field; the initiator's DATA_WIDTH defaults to it.
  localparam int CG_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RA   = 3'd2,
    RD   = 3'd3,
    RSP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [CG_DATA_WIDTH-1:0] rdata;
    logic                     err;
  } rsp_t;

endpackage

// File: rtl/cg_memory_initiator.sv
// CommonGoods memory initiator: accepts one client command at a time, runs it
// on the memory write or read channel, and returns a single response. Each
// wait for the memory is bounded by TIMEOUT_CYCLES; expiry yields rsp_err=1.
module cg_memory_initiator
  import cg_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = CG_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wen,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rready
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  rsp_t                  rsp_reg, rsp_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  expired;

  // Last waiting cycle allowed; a handshake on this cycle still succeeds.
  assign expired = (cnt_reg == CNT_LAST);

  // State, captured command, response and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rsp_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rsp_reg   <= rsp_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: command capture, channel handshakes, timeout exits.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rsp_next   = rsp_reg;
    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          state_next = cmd_we ? WR : RA;
        end
      end
      WR: begin
        if (mem_wready) begin
          rsp_next   = '{rdata: '0, err: 1'b0};
          state_next = RSP;
        end else if (expired) begin
          rsp_next   = '{rdata: '0, err: 1'b1};
          state_next = RSP;
        end
      end
      RA: begin
        // rready is already up in RA, so data arriving with arready is taken.
        if (mem_arready && mem_rvalid) begin
          rsp_next.rdata = mem_rdata;
          rsp_next.err   = 1'b0;
          state_next     = RSP;
        end else if (mem_arready) begin
          state_next = RD;
        end else if (expired) begin
          rsp_next   = '{rdata: '0, err: 1'b1};
          state_next = RSP;
        end
      end
      RD: begin
        if (mem_rvalid) begin
          rsp_next.rdata = mem_rdata;
          rsp_next.err   = 1'b0;
          state_next     = RSP;
        end else if (expired) begin
          rsp_next   = '{rdata: '0, err: 1'b1};
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Timeout counter: restarts on every entry to a wait state, saturates.
  always_comb begin
    cnt_next = '0;
    if ((state_next == state_reg) &&
        (state_reg == WR || state_reg == RA || state_reg == RD)) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    end
  end

  // Outputs decode from the registered state only; data buses read zero
  // whenever their channel is not active.
  assign cmd_ready   = (state_reg == IDLE);
  assign mem_wvalid  = (state_reg == WR);
  assign mem_wen     = (state_reg == WR);
  assign mem_waddr   = (state_reg == WR) ? addr_reg : '0;
  assign mem_wdata   = (state_reg == WR) ? wdata_reg : '0;
  assign mem_arvalid = (state_reg == RA);
  assign mem_araddr  = (state_reg == RA) ? addr_reg : '0;
  assign mem_rready  = (state_reg == RA) || (state_reg == RD);
  assign rsp_valid   = (state_reg == RSP);
  assign rsp_rdata   = (state_reg == RSP) ? rsp_reg.rdata : '0;
  assign rsp_err     = (state_reg == RSP) && rsp_reg.err;

endmodule

// File: tb/tb_cg_memory_initiator.sv
// Bench for cg_memory_initiator: a client driver, a delay-programmable memory
// responder, a transaction-level reference model and one per-cycle checker.
module tb_cg_memory_initiator;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int T  = 4;
  localparam logic [AW-1:0] BASE = 32'h510;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_wen, mem_wvalid, mem_wready;
  logic [AW-1:0] mem_waddr, mem_araddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_arvalid, mem_arready, mem_rvalid, mem_rready;

  cg_memory_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wen(mem_wen), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [2:0]    a;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] mem_store [8];
  int            wdelay = 0, ardelay = 0, rdelay = 0;
  int            w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic          rd_pend = 1'b0;
  logic [2:0]    rd_idx = '0;
  int            n_vec = 0, n_err = 0;
  int            last_lat = 0, wv_run = 0, last_wv_run = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;
  logic          first_rsp = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: grants each channel after the programmed number of waiting cycles.
  initial begin
    mem_wready = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_wready = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (!rst_n) begin
        w_cnt = 0; ar_cnt = 0; r_cnt = 0; rd_pend = 1'b0;
      end else begin
        if (rd_pend && mem_rready && !mem_arvalid) begin
          if (r_cnt == rdelay - 1) begin
            mem_rvalid = 1'b1; mem_rdata = mem_store[rd_idx]; rd_pend = 1'b0;
          end
          r_cnt++;
        end else begin
          rd_pend = 1'b0;
        end
        if (mem_arvalid) begin
          if (ar_cnt == ardelay) begin
            mem_arready = 1'b1;
            rd_idx = mem_araddr[2:0];
            if (rdelay == 0) begin
              mem_rvalid = 1'b1; mem_rdata = mem_store[rd_idx];
            end else begin
              rd_pend = 1'b1; r_cnt = 0;
            end
          end
          ar_cnt++;
        end else begin
          ar_cnt = 0;
        end
        if (mem_wvalid) begin
          if (w_cnt == wdelay) begin
            mem_wready = 1'b1; mem_store[mem_waddr[2:0]] = mem_wdata;
          end
          w_cnt++;
        end else begin
          w_cnt = 0;
        end
      end
    end
  end

  // Per-cycle checker against the oldest outstanding expected transaction.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() == 0) begin
          chk("idle_cmd_ready", cmd_ready, 1);
          chk("idle_quiet", {rsp_valid, mem_wvalid, mem_wen, mem_arvalid, mem_rready}, 0);
        end else begin
          cur = exp_q[0];
          chk("busy_cmd_ready", cmd_ready, 0);
          chk("chan_dir", (mem_wvalid & ~cur.we) | ((mem_arvalid | mem_rready) & cur.we), 0);
          if (mem_wvalid) begin
            chk("wen", mem_wen, 1);
            chk("waddr", mem_waddr, BASE + cur.a);
            chk("wdata", mem_wdata, cur.wdata);
          end
          if (mem_arvalid) begin
            chk("araddr", mem_araddr, BASE + cur.a);
            chk("rready_in_ra", mem_rready, 1);
          end
          if (rsp_valid) begin
            if (first_rsp) begin
              last_lat = cyc - cur.acc + 1;
              chk("latency", last_lat, cur.lat);
              first_rsp = 1'b0;
            end
            chk("rsp_err", rsp_err, cur.err);
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_mem_quiet", {mem_wvalid, mem_arvalid, mem_rready}, 0);
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              first_rsp = 1'b1;
            end
          end
        end
        if (mem_wvalid) wv_run++;
        else if (wv_run != 0) begin
          last_wv_run = wv_run;
          wv_run = 0;
        end
      end
    end
  end

  // Present one command, predict its outcome, and queue the expectation.
  task automatic issue(input logic we, input logic [2:0] a, input logic [DW-1:0] d,
                       input int wd, input int ard, input int rd);
    exp_t e;
    int   n, ra;
    logic ok;
    wdelay = wd; ardelay = ard; rdelay = rd;
    e.we = we; e.a = a; e.wdata = d; e.rdata = '0;
    if (we) begin
      ok = (wd <= T - 1);
      e.lat = 1 + ((wd < T - 1) ? wd : T - 1) + 1;
      if (ok) ref_mem[a] = d;
    end else begin
      ra = ((ard < T - 1) ? ard : T - 1) + 1;
      if (ard > T - 1) begin
        ok = 1'b0; e.lat = 1 + ra;
      end else if (rd == 0) begin
        ok = 1'b1; e.lat = 1 + ra;
      end else begin
        ok = ((rd - 1) <= T - 1);
        e.lat = 1 + ra + (((rd - 1) < T - 1) ? rd - 1 : T - 1) + 1;
      end
      if (ok) e.rdata = ref_mem[a];
    end
    e.err = !ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = BASE + a; cmd_wdata = d;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!cmd_ready && n < 50);
    chk("cmd_ready_wait", (n < 50), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom;
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  // Wait for the response, stall it for 'hold' cycles, then accept it.
  task automatic finish_rsp(input int hold);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!rsp_valid && n < 100);
    chk("rsp_wait", (n < 100), 1);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [2:0] a, input logic [DW-1:0] d,
                     input int wd, input int ard, input int rd, input int hold);
    issue(we, a, d, wd, ard, rd);
    finish_rsp(hold);
    $display("txn %s addr=0x%0h wdata=0x%0h -> rdata=0x%0h err=%0d lat=%0d",
             we ? "WR" : "RD", BASE + a, d, last_rdata, last_err, last_lat);
  endtask

  // Directed scenarios first, then randomized traffic.
  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = '0; mem_store[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outputs", |{rsp_valid, rsp_err, rsp_rdata, mem_wen, mem_wvalid, mem_waddr,
                         mem_wdata, mem_arvalid, mem_araddr, mem_rready}, 0);
    rst_n = 1'b1;

    txn(1'b1, 3'd4, 32'h114, 0, 0, 0, 0);
    chk("w514_lat", last_lat, 2);
    chk("w514_err", last_err, 0);
    chk("w514_rdata", last_rdata, 0);
    chk("w514_wvalid_cycles", last_wv_run, 1);

    txn(1'b1, 3'd5, 32'h214, 0, 0, 0, 0);
    txn(1'b1, 3'd6, 32'hAAAAAAAA, 1, 0, 0, 1);
    txn(1'b0, 3'd4, '0, 0, 0, 0, 0);
    chk("r514_rdata", last_rdata, 32'h114);
    chk("r514_lat", last_lat, 2);

    txn(1'b1, 3'd6, 32'h314, 0, 0, 0, 0);
    txn(1'b0, 3'd6, '0, 0, 0, 0, 0);
    chk("r516_rdata", last_rdata, 32'h314);

    txn(1'b0, 3'd5, '0, 0, 3, 3, 0);
    chk("slow_read_rdata", last_rdata, 32'h214);
    chk("slow_read_lat", last_lat, 8);

    txn(1'b1, 3'd7, 32'h55, 6, 0, 0, 0);
    chk("wr_timeout_err", last_err, 1);
    chk("wr_timeout_rdata", last_rdata, 0);
    chk("wr_timeout_wvalid_cycles", last_wv_run, 4);
    chk("wr_timeout_lat", last_lat, 5);

    txn(1'b1, 3'd3, 32'h77, 0, 0, 0, 5);
    issue(1'b0, 3'd3, '0, 0, 0, 6);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(mem_rready && !mem_arvalid) && n < 20);
    chk("reach_rd", (n < 20), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cmd_ready", cmd_ready, 1);
    chk("async_rst_outputs", |{rsp_valid, rsp_err, rsp_rdata, mem_wen, mem_wvalid, mem_waddr,
                               mem_wdata, mem_arvalid, mem_araddr, mem_rready}, 0);
    exp_q.delete();
    first_rsp = 1'b1;
    wv_run = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    $display("txn RST during read of addr=0x%0h", BASE + 3);

    txn(1'b0, 3'd3, '0, 0, 0, 0, 0);
    chk("post_rst_rdata", last_rdata, 32'h77);

    for (int i = 0; i < 150; i++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
          $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit in case a wait somewhere never resolves.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
